// File: rtl/keypad_scanner_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Key codes follow the physical layout: code = row*4 + col.
package keypad_pkg;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  typedef logic [1:0] idx_t;

  localparam logic [4:0] KEY_1    = 5'd0;
  localparam logic [4:0] KEY_2    = 5'd1;
  localparam logic [4:0] KEY_3    = 5'd2;
  localparam logic [4:0] KEY_PLUS = 5'd3;
  localparam logic [4:0] KEY_4    = 5'd4;
  localparam logic [4:0] KEY_5    = 5'd5;
  localparam logic [4:0] KEY_6    = 5'd6;
  localparam logic [4:0] KEY_EQ   = 5'd7;
  localparam logic [4:0] KEY_7    = 5'd8;
  localparam logic [4:0] KEY_8    = 5'd9;
  localparam logic [4:0] KEY_9    = 5'd10;
  localparam logic [4:0] KEY_0    = 5'd13;

  // Scanning from the top down lets the lowest pressed column win.
  function automatic idx_t lowest_zero(input logic [COLS-1:0] c);
    idx_t idx;
    idx = '0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (!c[i]) idx = idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Key-event interface between the scanner (master) and the calculator front-end (slave).
interface keypad_scanner_if;
  logic [4:0] out;
  logic       flag;
  logic       key_pulse;

  modport master (output out, output flag, output key_pulse);
  modport slave  (input  out, input  flag, input  key_pulse);
endinterface

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchroniser; resets to all-ones so idle pulled-up columns never look pressed.
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: drives rows one-hot-low, debounces the columns on scan ticks
// and emits one key code plus a one-cycle strobe per accepted press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1024,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic [COLS-1:0]   column,
  output logic [ROWS-1:0]   line,
  keypad_scanner_if.master  key_if
);

  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);

  logic [PRE_W-1:0] pre_q;
  logic             tick;
  logic [COLS-1:0]  col_sync;

  state_t           state_q, state_d;
  idx_t             row_q, row_d;
  idx_t             col_q, col_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       out_q, out_d;
  logic             flag_q, flag_d;
  logic             pulse_q, pulse_d;

  logic             pressed;
  logic             same_col;
  logic             cnt_done;

  sync_2ff #(.WIDTH(COLS)) u_sync (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .d      (column),
    .q      (col_sync)
  );

  assign tick = (pre_q == PRE_W'(SCAN_DIV - 1));

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) pre_q <= '0;
    else if (tick) pre_q <= '0;
    else pre_q <= pre_q + PRE_W'(1);
  end

  assign pressed  = (col_sync != '1);
  assign same_col = pressed && (lowest_zero(col_sync) == col_q);
  // One counter serves both press and release qualification; it is cleared between uses.
  assign cnt_done = ((cnt_q + CNT_W'(1)) >= CNT_W'(DEBOUNCE_CNT));

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SCAN;
      row_q   <= '0;
      col_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      flag_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      flag_q  <= flag_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    flag_d  = flag_q;
    pulse_d = 1'b0;
    if (tick) begin
      case (state_q)
        SCAN: begin
          if (pressed) begin
            col_d   = lowest_zero(col_sync);
            cnt_d   = CNT_W'(1);
            state_d = DEBOUNCE;
          end else begin
            row_d = row_q + idx_t'(1);
          end
        end
        DEBOUNCE: begin
          if (same_col) begin
            if (cnt_done) begin
              state_d = HELD;
              out_d   = {1'b0, row_q, col_q};
              flag_d  = 1'b1;
              pulse_d = 1'b1;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            state_d = SCAN;
            row_d   = row_q + idx_t'(1);
            cnt_d   = '0;
          end
        end
        HELD: begin
          // Any low column, even a different key in this row, restarts release qualification.
          if (!pressed) begin
            if (cnt_done) begin
              state_d = SCAN;
              flag_d  = 1'b0;
              row_d   = row_q + idx_t'(1);
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_d = '0;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  assign line             = ~(ROWS'(1) << row_q);
  assign key_if.out       = out_q;
  assign key_if.flag      = flag_q;
  assign key_if.key_pulse = pulse_q;

endmodule
